mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports, the single memory port and the busy flag.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req0_valid, req0_ready, req0_we;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          rsp0_valid;
   logic [DW-1:0] rsp0_rdata;

   logic          req1_valid, req1_ready, req1_we;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp1_valid;
   logic [DW-1:0] rsp1_rdata;

   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          busy;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      input  mem_rdata,
      output req0_ready, rsp0_valid, rsp0_rdata,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      output mem_rdata,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter. One access in flight at a time:
// handshake (IDLE) -> memory strobe (ISSUE) -> response pulse (RESP).
// Simultaneous requests alternate via a 1-bit priority pointer.
module mem_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t        state_q;
   logic          prio_q;      // requester favoured on contention
   logic          own_q;       // owner of the access in flight
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          mem_en_q;
   logic [1:0]    rsp_vld_q;

   logic          idle_ok, gnt0, gnt1;

   // Grant decode; rst_n gates it so ready stays low throughout reset.
   always_comb begin
      idle_ok = rst_n && (state_q == IDLE);
      gnt0    = idle_ok && bus.req0_valid && (!bus.req1_valid || !prio_q);
      gnt1    = idle_ok && bus.req1_valid && (!bus.req0_valid ||  prio_q);
   end

   // Port drive: memory fields are zeroed outside the strobe cycle, read data
   // is a pass-through only during a read response.
   always_comb begin
      bus.req0_ready = gnt0;
      bus.req1_ready = gnt1;
      bus.mem_en     = mem_en_q;
      bus.mem_we     = mem_en_q & we_q;
      bus.mem_addr   = mem_en_q ? addr_q  : '0;
      bus.mem_wdata  = mem_en_q ? wdata_q : '0;
      bus.rsp0_valid = rsp_vld_q[0];
      bus.rsp1_valid = rsp_vld_q[1];
      bus.rsp0_rdata = (rsp_vld_q[0] && !we_q) ? bus.mem_rdata : '0;
      bus.rsp1_rdata = (rsp_vld_q[1] && !we_q) ? bus.mem_rdata : '0;
      bus.busy       = (state_q != IDLE);
   end

   // Transaction FSM: latch the winner, strobe memory once, pulse the owner's response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         prio_q    <= 1'b0;
         own_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mem_en_q  <= 1'b0;
         rsp_vld_q <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  own_q    <= gnt1;
                  we_q     <= gnt1 ? bus.req1_we    : bus.req0_we;
                  addr_q   <= gnt1 ? bus.req1_addr  : bus.req0_addr;
                  wdata_q  <= gnt1 ? bus.req1_wdata : bus.req0_wdata;
                  prio_q   <= ~gnt1;
                  mem_en_q <= 1'b1;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en_q  <= 1'b0;
               rsp_vld_q <= own_q ? 2'b10 : 2'b01;
               state_q   <= RESP;
            end
            RESP: begin
               rsp_vld_q <= 2'b00;
               state_q   <= IDLE;
            end
            default: begin
               mem_en_q  <= 1'b0;
               rsp_vld_q <= 2'b00;
               state_q   <= IDLE;
            end
         endcase
      end
   end

endmodule
